debug_reg_arb: RTL and testbench

- AXI4-Lite master front-end that shares the single debug/control register slave (soft-reset and ID registers) between NUM_REQ internal requesters.
- Each requester issues a simple single-beat read or write command.
- The block arbitrates round-robin and sequences the AW/W/B or AR/R channel handshakes.
- It returns read data and response code to the winning requester with a one-cycle ack.

---
 rtl/debug_reg_arb_pkg.sv | 32 +++
 rtl/debug_reg_arb_if.sv | 39 +++
 rtl/debug_reg_arb_rr.sv | 39 +++
 rtl/debug_reg_arb.sv | 191 +++++++++++++++++++
 tb/tb_debug_reg_arb.sv | 312 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/debug_reg_arb_pkg.sv
// Shared types and constants for the debug/control register arbiter.
//   state_e : transaction sequencer states
//   rsp_t   : response payload returned to the requesters
//   RESP_*  : AXI response codes, register offsets of the debug slave
package debug_reg_pkg;

   localparam int unsigned DATA_W = 32;

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_WR      = 3'd1,
      S_WRESP   = 3'd2,
      S_RD_ADDR = 3'd3,
      S_RD_DATA = 3'd4
   } state_e;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] RESP_DECERR = 2'b11;

   localparam logic [31:0] SFT_RST      = 32'h0;
   localparam logic [31:0] ID0          = 32'h0;
   localparam logic [31:0] ID1          = 32'h4;
   localparam logic [31:0] RST_CHK      = 32'h8;
   localparam logic [31:0] RRESP_MIRROR = 32'hC;

   typedef struct packed {
      logic [1:0]        resp;
      logic [DATA_W-1:0] rdata;
   } rsp_t;

endpackage

// File: rtl/debug_reg_arb_if.sv
// AXI4-Lite channel bundle between the arbiter (master) and the debug register slave.
//   AW/W/B : write address, write data, write response
//   AR/R   : read address, read data/response
interface debug_reg_arb_if
   import debug_reg_pkg::*;
#(
   parameter int unsigned ADDR_W = 32
);
   logic              m_axi_awvalid_user;
   logic [ADDR_W-1:0] m_axi_awaddr_user;
   logic              m_axi_awready_user;
   logic              m_axi_wvalid_user;
   logic [DATA_W-1:0] m_axi_wdata_user;
   logic              m_axi_wready_user;
   logic              m_axi_bvalid_user;
   logic [1:0]        m_axi_bresp_user;
   logic              m_axi_bready_user;
   logic              m_axi_arvalid_user;
   logic [ADDR_W-1:0] m_axi_araddr_user;
   logic              m_axi_arready_user;
   logic              m_axi_rvalid_user;
   logic [DATA_W-1:0] m_axi_rdata_user;
   logic [1:0]        m_axi_rresp_user;
   logic              m_axi_rready_user;

   modport master (
      output m_axi_awvalid_user, m_axi_awaddr_user, m_axi_wvalid_user, m_axi_wdata_user,
             m_axi_bready_user, m_axi_arvalid_user, m_axi_araddr_user, m_axi_rready_user,
      input  m_axi_awready_user, m_axi_wready_user, m_axi_bvalid_user, m_axi_bresp_user,
             m_axi_arready_user, m_axi_rvalid_user, m_axi_rdata_user, m_axi_rresp_user
   );

   modport slave (
      input  m_axi_awvalid_user, m_axi_awaddr_user, m_axi_wvalid_user, m_axi_wdata_user,
             m_axi_bready_user, m_axi_arvalid_user, m_axi_araddr_user, m_axi_rready_user,
      output m_axi_awready_user, m_axi_wready_user, m_axi_bvalid_user, m_axi_bresp_user,
             m_axi_arready_user, m_axi_rvalid_user, m_axi_rdata_user, m_axi_rresp_user
   );
endinterface

// File: rtl/debug_reg_arb_rr.sv
// Combinational round-robin picker: first set request strictly after ptr_i, wrapping.
//   req_i     : request vector
//   ptr_i     : index of the previous winner
//   any_o     : some request is set
//   gnt_oh_o  : one-hot grant
//   gnt_idx_o : binary grant index
module debug_rr_arb #(
   parameter  int unsigned NUM_REQ = 2,
   localparam int unsigned IDX_W   = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req_i,
   input  logic [IDX_W-1:0]   ptr_i,
   output logic               any_o,
   output logic [NUM_REQ-1:0] gnt_oh_o,
   output logic [IDX_W-1:0]   gnt_idx_o
);

   int unsigned cand;

   // Walk offsets 1..NUM_REQ from the pointer; the first hit wins.
   always_comb begin
      any_o     = 1'b0;
      gnt_oh_o  = '0;
      gnt_idx_o = '0;
      cand      = 0;
      for (int unsigned off = 1; off <= NUM_REQ; off++) begin
         cand = 32'(ptr_i) + off;
         if (cand >= NUM_REQ) cand = cand - NUM_REQ;
         for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (!any_o && (i == cand) && req_i[i]) begin
               any_o       = 1'b1;
               gnt_oh_o[i] = 1'b1;
               gnt_idx_o   = IDX_W'(i);
            end
         end
      end
   end

endmodule

// File: rtl/debug_reg_arb.sv
// AXI4-Lite master front-end sharing the debug register slave between NUM_REQ requesters.
//   axi_clk/axi_aresetn : clock, async active-low reset
//   req_valid/wr/addr/wdata : per-requester single-beat command, held until req_ack
//   req_ack   : one-cycle completion pulse to the granted requester
//   rsp_rdata : read data of the last completed read
//   rsp_resp  : AXI response of the last completed transaction
//   busy      : transaction in flight
//   m_axi     : AXI4-Lite master channels
module debug_reg_arb
   import debug_reg_pkg::*;
#(
   parameter int unsigned NUM_REQ = 2,
   parameter int unsigned ADDR_W  = 32
) (
   input  logic                      axi_clk,
   input  logic                      axi_aresetn,
   input  logic [NUM_REQ-1:0]        req_valid,
   input  logic [NUM_REQ-1:0]        req_wr,
   input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
   input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
   output logic [NUM_REQ-1:0]        req_ack,
   output logic [DATA_W-1:0]         rsp_rdata,
   output logic [1:0]                rsp_resp,
   output logic                      busy,
   debug_reg_arb_if.master           m_axi
);

   localparam int unsigned IDX_W = $clog2(NUM_REQ);

   state_e              state_q, state_d;
   logic [IDX_W-1:0]    ptr_q, ptr_d;
   logic [NUM_REQ-1:0]  gnt_oh_q, gnt_oh_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [DATA_W-1:0]   wdata_q, wdata_d;
   logic                awvalid_q, awvalid_d;
   logic                wvalid_q, wvalid_d;
   logic                bready_q, bready_d;
   logic                arvalid_q, arvalid_d;
   logic                rready_q, rready_d;
   logic [NUM_REQ-1:0]  ack_q, ack_d;
   rsp_t                rsp_q, rsp_d;
   logic                busy_q, busy_d;

   logic                arb_any;
   logic [NUM_REQ-1:0]  arb_oh;
   logic [IDX_W-1:0]    arb_idx;
   logic                sel_wr;
   logic [ADDR_W-1:0]   sel_addr;
   logic [DATA_W-1:0]   sel_wdata;

   // A requester being acked this cycle still shows valid; mask it so it is not re-granted.
   debug_rr_arb #(.NUM_REQ(NUM_REQ)) u_rr_arb (
      .req_i     (req_valid & ~ack_q),
      .ptr_i     (ptr_q),
      .any_o     (arb_any),
      .gnt_oh_o  (arb_oh),
      .gnt_idx_o (arb_idx)
   );

   // Command mux for the arbiter winner.
   always_comb begin
      sel_wr    = 1'b0;
      sel_addr  = '0;
      sel_wdata = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         if (arb_oh[i]) begin
            sel_wr    = req_wr[i];
            sel_addr  = req_addr[i*ADDR_W +: ADDR_W];
            sel_wdata = req_wdata[i*DATA_W +: DATA_W];
         end
      end
   end

   // Transaction sequencer: next state and registered outputs.
   always_comb begin
      state_d   = state_q;
      ptr_d     = ptr_q;
      gnt_oh_d  = gnt_oh_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      awvalid_d = awvalid_q;
      wvalid_d  = wvalid_q;
      bready_d  = bready_q;
      arvalid_d = arvalid_q;
      rready_d  = rready_q;
      ack_d     = '0;
      rsp_d     = rsp_q;
      busy_d    = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (arb_any) begin
               gnt_oh_d = arb_oh;
               ptr_d    = arb_idx;
               addr_d   = {sel_addr[ADDR_W-1:2], 2'b00};
               wdata_d  = sel_wdata;
               if (sel_wr) begin
                  awvalid_d = 1'b1;
                  wvalid_d  = 1'b1;
                  state_d   = S_WR;
               end else begin
                  arvalid_d = 1'b1;
                  state_d   = S_RD_ADDR;
               end
            end
         end
         S_WR: begin
            // AW and W complete independently; leave once both are done.
            if (awvalid_q && m_axi.m_axi_awready_user) awvalid_d = 1'b0;
            if (wvalid_q && m_axi.m_axi_wready_user)   wvalid_d  = 1'b0;
            if (!awvalid_d && !wvalid_d) begin
               bready_d = 1'b1;
               state_d  = S_WRESP;
            end
         end
         S_WRESP: begin
            if (m_axi.m_axi_bvalid_user && bready_q) begin
               bready_d   = 1'b0;
               rsp_d.resp = m_axi.m_axi_bresp_user;
               ack_d      = gnt_oh_q;
               state_d    = S_IDLE;
            end
         end
         S_RD_ADDR: begin
            if (m_axi.m_axi_arready_user) begin
               arvalid_d = 1'b0;
               rready_d  = 1'b1;
               state_d   = S_RD_DATA;
            end
         end
         S_RD_DATA: begin
            if (m_axi.m_axi_rvalid_user && rready_q) begin
               rsp_d.rdata = m_axi.m_axi_rdata_user;
               rsp_d.resp  = m_axi.m_axi_rresp_user;
               ack_d       = gnt_oh_q;
               rready_d    = 1'b0;
               state_d     = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
      busy_d = (state_d != S_IDLE);
   end

   // State and output registers.
   always_ff @(posedge axi_clk or negedge axi_aresetn) begin
      if (!axi_aresetn) begin
         state_q   <= S_IDLE;
         ptr_q     <= IDX_W'(NUM_REQ - 1);
         gnt_oh_q  <= '0;
         addr_q    <= '0;
         wdata_q   <= '0;
         awvalid_q <= 1'b0;
         wvalid_q  <= 1'b0;
         bready_q  <= 1'b0;
         arvalid_q <= 1'b0;
         rready_q  <= 1'b0;
         ack_q     <= '0;
         rsp_q     <= '0;
         busy_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         ptr_q     <= ptr_d;
         gnt_oh_q  <= gnt_oh_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         awvalid_q <= awvalid_d;
         wvalid_q  <= wvalid_d;
         bready_q  <= bready_d;
         arvalid_q <= arvalid_d;
         rready_q  <= rready_d;
         ack_q     <= ack_d;
         rsp_q     <= rsp_d;
         busy_q    <= busy_d;
      end
   end

   assign req_ack   = ack_q;
   assign rsp_rdata = rsp_q.rdata;
   assign rsp_resp  = rsp_q.resp;
   assign busy      = busy_q;

   assign m_axi.m_axi_awvalid_user = awvalid_q;
   assign m_axi.m_axi_awaddr_user  = addr_q;
   assign m_axi.m_axi_wvalid_user  = wvalid_q;
   assign m_axi.m_axi_wdata_user   = wdata_q;
   assign m_axi.m_axi_bready_user  = bready_q;
   assign m_axi.m_axi_arvalid_user = arvalid_q;
   assign m_axi.m_axi_araddr_user  = addr_q;
   assign m_axi.m_axi_rready_user  = rready_q;

endmodule

// File: tb/tb_debug_reg_arb.sv
// Directed bench for debug_reg_arb with a small reactive debug register slave.
module tb_debug_reg_arb;
   import debug_reg_pkg::*;

   localparam int unsigned N  = 2;
   localparam int unsigned AW = 32;

   logic              axi_clk;
   logic              axi_aresetn;
   logic [N-1:0]      req_valid;
   logic [N-1:0]      req_wr;
   logic [N*AW-1:0]   req_addr;
   logic [N*32-1:0]   req_wdata;
   logic [N-1:0]      req_ack;
   logic [31:0]       rsp_rdata;
   logic [1:0]        rsp_resp;
   logic              busy;

   debug_reg_arb_if #(.ADDR_W(AW)) bus ();

   debug_reg_arb #(.NUM_REQ(N), .ADDR_W(AW)) dut (
      .axi_clk     (axi_clk),
      .axi_aresetn (axi_aresetn),
      .req_valid   (req_valid),
      .req_wr      (req_wr),
      .req_addr    (req_addr),
      .req_wdata   (req_wdata),
      .req_ack     (req_ack),
      .rsp_rdata   (rsp_rdata),
      .rsp_resp    (rsp_resp),
      .busy        (busy),
      .m_axi       (bus)
   );

   initial axi_clk = 1'b0;
   always #5 axi_clk = ~axi_clk;

   // ---------------- slave model ----------------
   int          aw_wait, w_wait;
   logic        b_block;
   logic [1:0]  bresp_cfg, rresp_cfg;
   int          aw_cnt, w_cnt;
   logic        aw_got, w_got;
   logic [31:0] aw_addr_l, w_data_l;
   logic        s_bvalid, s_rvalid;
   logic [1:0]  s_bresp, s_rresp;
   logic [31:0] s_rdata, sft_rst, last_araddr;
   logic        aw_hs, w_hs, ar_hs;
   logic [31:0] wr_addr_eff, wr_data_eff;

   assign aw_hs = bus.m_axi_awvalid_user && bus.m_axi_awready_user;
   assign w_hs  = bus.m_axi_wvalid_user && bus.m_axi_wready_user;
   assign ar_hs = bus.m_axi_arvalid_user && bus.m_axi_arready_user;
   assign wr_addr_eff = aw_hs ? bus.m_axi_awaddr_user : aw_addr_l;
   assign wr_data_eff = w_hs ? bus.m_axi_wdata_user : w_data_l;

   assign bus.m_axi_awready_user = (aw_cnt >= aw_wait);
   assign bus.m_axi_wready_user  = (w_cnt >= w_wait);
   assign bus.m_axi_arready_user = 1'b1;
   assign bus.m_axi_bvalid_user  = s_bvalid;
   assign bus.m_axi_bresp_user   = s_bresp;
   assign bus.m_axi_rvalid_user  = s_rvalid;
   assign bus.m_axi_rdata_user   = s_rdata;
   assign bus.m_axi_rresp_user   = s_rresp;

   function automatic logic [31:0] rd_val(input logic [31:0] a, input logic [31:0] sr);
      case (a)
         ID0:     return 32'h0123_4567;
         ID1:     return 32'h89ab_cdef;
         RST_CHK: return sr;
         default: return 32'h0;
      endcase
   endfunction

   always @(posedge axi_clk or negedge axi_aresetn) begin
      if (!axi_aresetn) begin
         aw_cnt <= 0; w_cnt <= 0; aw_got <= 1'b0; w_got <= 1'b0;
         aw_addr_l <= '0; w_data_l <= '0;
         s_bvalid <= 1'b0; s_bresp <= '0; s_rvalid <= 1'b0; s_rdata <= '0; s_rresp <= '0;
         sft_rst <= '0; last_araddr <= '0;
      end else begin
         if (bus.m_axi_awvalid_user && !bus.m_axi_awready_user) aw_cnt <= aw_cnt + 1;
         else if (aw_hs) aw_cnt <= 0;
         if (bus.m_axi_wvalid_user && !bus.m_axi_wready_user) w_cnt <= w_cnt + 1;
         else if (w_hs) w_cnt <= 0;
         if (aw_hs) begin aw_got <= 1'b1; aw_addr_l <= bus.m_axi_awaddr_user; end
         if (w_hs)  begin w_got <= 1'b1;  w_data_l <= bus.m_axi_wdata_user;  end
         if ((aw_got || aw_hs) && (w_got || w_hs) && !b_block && !s_bvalid) begin
            s_bvalid <= 1'b1;
            s_bresp  <= bresp_cfg;
            aw_got   <= 1'b0;
            w_got    <= 1'b0;
            if (wr_addr_eff == SFT_RST) sft_rst <= wr_data_eff;
         end
         if (s_bvalid && bus.m_axi_bready_user) s_bvalid <= 1'b0;
         if (ar_hs) begin
            s_rvalid    <= 1'b1;
            s_rdata     <= rd_val(bus.m_axi_araddr_user, sft_rst);
            s_rresp     <= rresp_cfg;
            last_araddr <= bus.m_axi_araddr_user;
         end
         if (s_rvalid && bus.m_axi_rready_user) s_rvalid <= 1'b0;
      end
   end

   // ---------------- checking helpers ----------------
   int compared   = 0;
   int mismatched = 0;

   task automatic tick();
      @(negedge axi_clk);
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic set_cmd(input int idx, input logic wr, input logic [31:0] addr,
                          input logic [31:0] wdata);
      req_wr[idx]             = wr;
      req_addr[idx*AW +: AW]  = addr;
      req_wdata[idx*32 +: 32] = wdata;
   endtask

   // Returns the ack vector seen, or 0 if none arrived within the budget.
   task automatic wait_ack(output logic [N-1:0] ack);
      ack = '0;
      for (int n = 0; n < 40; n++) begin
         tick();
         if (req_ack != '0) begin
            ack = req_ack;
            break;
         end
      end
   endtask

   logic [N-1:0] ack;

   initial begin
      req_valid = '0; req_wr = '0; req_addr = '0; req_wdata = '0;
      aw_wait = 0; w_wait = 0; b_block = 1'b0; bresp_cfg = RESP_OKAY; rresp_cfg = RESP_OKAY;
      axi_aresetn = 1'b0;
      repeat (3) tick();

      // Reset state
      check("rst_ack",     64'(req_ack), 64'h0);
      check("rst_busy",    64'(busy), 64'h0);
      check("rst_awvalid", 64'(bus.m_axi_awvalid_user), 64'h0);
      check("rst_wvalid",  64'(bus.m_axi_wvalid_user), 64'h0);
      check("rst_arvalid", 64'(bus.m_axi_arvalid_user), 64'h0);
      check("rst_bready",  64'(bus.m_axi_bready_user), 64'h0);
      check("rst_rdata",   64'(rsp_rdata), 64'h0);
      axi_aresetn = 1'b1;
      tick();

      // 1: write 0x1 to 0x0 from req0, zero-wait slave
      set_cmd(0, 1'b1, 32'h0, 32'h1);
      req_valid = 2'b01;
      tick();
      check("t1_awvalid", 64'(bus.m_axi_awvalid_user), 64'h1);
      check("t1_wvalid",  64'(bus.m_axi_wvalid_user), 64'h1);
      check("t1_awaddr",  64'(bus.m_axi_awaddr_user), 64'h0);
      check("t1_wdata",   64'(bus.m_axi_wdata_user), 64'h1);
      check("t1_busy",    64'(busy), 64'h1);
      tick();
      check("t1_aw_drop", 64'(bus.m_axi_awvalid_user), 64'h0);
      check("t1_w_drop",  64'(bus.m_axi_wvalid_user), 64'h0);
      check("t1_bready",  64'(bus.m_axi_bready_user), 64'h1);
      check("t1_noack",   64'(req_ack), 64'h0);
      tick();
      check("t1_ack",     64'(req_ack), 64'h1);
      check("t1_resp",    64'(rsp_resp), 64'h0);
      check("t1_idle",    64'(busy), 64'h0);
      check("t1_b_drop",  64'(bus.m_axi_bready_user), 64'h0);
      req_valid = 2'b00;
      tick();
      check("t1_ack_1cyc", 64'(req_ack), 64'h0);

      // 2: read ID1 from req1
      set_cmd(1, 1'b0, ID1, 32'h0);
      req_valid = 2'b10;
      tick();
      check("t2_arvalid", 64'(bus.m_axi_arvalid_user), 64'h1);
      check("t2_araddr",  64'(bus.m_axi_araddr_user), 64'h4);
      check("t2_no_aw",   64'(bus.m_axi_awvalid_user), 64'h0);
      tick();
      check("t2_ar_drop", 64'(bus.m_axi_arvalid_user), 64'h0);
      check("t2_rready",  64'(bus.m_axi_rready_user), 64'h1);
      tick();
      check("t2_ack",     64'(req_ack), 64'h2);
      check("t2_rdata",   64'(rsp_rdata), 64'h89ab_cdef);
      check("t2_resp",    64'(rsp_resp), 64'h0);
      req_valid = 2'b00;
      tick();
      check("t2_ack_1cyc", 64'(req_ack), 64'h0);
      check("t2_rdata_hold", 64'(rsp_rdata), 64'h89ab_cdef);

      // 3: both requesters read continuously -> strict alternation starting at 0
      set_cmd(0, 1'b0, ID0, 32'h0);
      set_cmd(1, 1'b0, ID1, 32'h0);
      req_valid = 2'b11;
      for (int k = 0; k < 4; k++) begin
         wait_ack(ack);
         check($sformatf("t3_grant%0d", k), 64'(ack), (k % 2 == 0) ? 64'h1 : 64'h2);
         check($sformatf("t3_rdata%0d", k), 64'(rsp_rdata),
               (k % 2 == 0) ? 64'h0123_4567 : 64'h89ab_cdef);
         if (k == 3) req_valid = 2'b00;
      end
      tick();
      check("t3_idle", 64'(busy), 64'h0);

      // Low address bits are cleared; reads back the value written in test 1
      set_cmd(0, 1'b0, 32'hB, 32'h0);
      req_valid = 2'b01;
      wait_ack(ack);
      check("al_ack",    64'(ack), 64'h1);
      check("al_araddr", 64'(last_araddr), 64'h8);
      check("al_rdata",  64'(rsp_rdata), 64'h1);
      req_valid = 2'b00;
      tick();

      // 4: wready held low for 3 cycles
      w_wait = 3;
      set_cmd(1, 1'b1, RRESP_MIRROR, 32'hA5A5_0F0F);
      req_valid = 2'b10;
      tick();
      check("t4_aw_c1", 64'(bus.m_axi_awvalid_user), 64'h1);
      check("t4_w_c1",  64'(bus.m_axi_wvalid_user), 64'h1);
      check("t4_awaddr", 64'(bus.m_axi_awaddr_user), 64'hC);
      for (int c = 2; c <= 4; c++) begin
         tick();
         check($sformatf("t4_aw_c%0d", c), 64'(bus.m_axi_awvalid_user), 64'h0);
         check($sformatf("t4_w_c%0d", c),  64'(bus.m_axi_wvalid_user), 64'h1);
         check($sformatf("t4_wd_c%0d", c), 64'(bus.m_axi_wdata_user), 64'hA5A5_0F0F);
         check($sformatf("t4_br_c%0d", c), 64'(bus.m_axi_bready_user), 64'h0);
      end
      tick();
      check("t4_w_drop", 64'(bus.m_axi_wvalid_user), 64'h0);
      check("t4_bready", 64'(bus.m_axi_bready_user), 64'h1);
      check("t4_noack",  64'(req_ack), 64'h0);
      tick();
      check("t4_ack", 64'(req_ack), 64'h2);
      req_valid = 2'b00;
      for (int c = 0; c < 3; c++) begin
         tick();
         check($sformatf("t4_single%0d", c), 64'(req_ack), 64'h0);
      end
      w_wait = 0;

      // 5: SLVERR passes through, following request is normal
      rresp_cfg = RESP_SLVERR;
      set_cmd(0, 1'b0, ID1, 32'h0);
      req_valid = 2'b01;
      wait_ack(ack);
      check("t5_ack",   64'(ack), 64'h1);
      check("t5_resp",  64'(rsp_resp), 64'h2);
      check("t5_rdata", 64'(rsp_rdata), 64'h89ab_cdef);
      req_valid = 2'b00;
      rresp_cfg = RESP_OKAY;
      tick();
      set_cmd(1, 1'b0, ID0, 32'h0);
      req_valid = 2'b10;
      wait_ack(ack);
      check("t5_next_ack",   64'(ack), 64'h2);
      check("t5_next_resp",  64'(rsp_resp), 64'h0);
      check("t5_next_rdata", 64'(rsp_rdata), 64'h0123_4567);
      req_valid = 2'b00;
      tick();

      // 6: async reset while waiting in WRESP
      b_block = 1'b1;
      set_cmd(0, 1'b1, SFT_RST, 32'h2);
      req_valid = 2'b01;
      tick();
      tick();
      check("t6_in_wresp", 64'(bus.m_axi_bready_user), 64'h1);
      check("t6_busy",     64'(busy), 64'h1);
      axi_aresetn = 1'b0;
      #1;
      check("t6_bready0", 64'(bus.m_axi_bready_user), 64'h0);
      check("t6_busy0",   64'(busy), 64'h0);
      check("t6_rdata0",  64'(rsp_rdata), 64'h0);
      check("t6_resp0",   64'(rsp_resp), 64'h0);
      check("t6_ack0",    64'(req_ack), 64'h0);
      req_valid = 2'b00;
      b_block = 1'b0;
      tick();
      tick();
      check("t6_rst_noack", 64'(req_ack), 64'h0);
      axi_aresetn = 1'b1;
      set_cmd(0, 1'b0, ID1, 32'h0);
      set_cmd(1, 1'b0, ID0, 32'h0);
      req_valid = 2'b11;
      wait_ack(ack);
      check("t6_first", 64'(ack), 64'h1);
      check("t6_first_rdata", 64'(rsp_rdata), 64'h89ab_cdef);
      req_valid = 2'b10;
      wait_ack(ack);
      check("t6_second", 64'(ack), 64'h2);
      check("t6_second_rdata", 64'(rsp_rdata), 64'h0123_4567);
      req_valid = 2'b00;
      tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
